// File: rtl/fetch_unit.sv
// Fetch stage plus F/D pipeline register: owns the PC, reads instruction memory,
// pairs two-word (immediate) instructions and presents them to decode.
module fetch_unit #(
  parameter int ADDR_W  = 16,  // must not exceed 16: reset vector is taken from IMEM_DATA
  parameter int IMM_BIT = 0,
  parameter int SRC_LSB = 5,
  parameter int DST_LSB = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_ENB,
  input  logic              F_D_ENB,
  input  logic              FLUSH_BRANCH,
  input  logic [ADDR_W-1:0] BRANCH_TARGET,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic [15:0]       IMEM_DATA,
  output logic [15:0]       INSTR_F_D,
  output logic [15:0]       IMM_F_D,
  output logic [ADDR_W-1:0] PC_F_D,
  output logic              VALID_F_D,
  output logic [2:0]        src_F_D,
  output logic [2:0]        dst_F_D
);

  typedef enum logic [1:0] {S_VEC, S_RUN, S_IMM} state_t;

  typedef struct packed {
    logic [15:0]       instr;
    logic [15:0]       imm;
    logic [ADDR_W-1:0] pc;
    logic              valid;
  } fd_t;

  localparam fd_t FD_BUBBLE = '0;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_pc_inc;
  logic [15:0]       r_hold, w_hold_nxt;
  fd_t               r_fd, w_fd_nxt;
  logic              w_stall;

  assign w_stall  = !PC_ENB || !F_D_ENB;
  assign w_pc_inc = r_pc + ADDR_W'(1);  // wraps silently at 2^ADDR_W

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_VEC;
      r_pc    <= '0;
      r_hold  <= '0;
      r_fd    <= FD_BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_hold  <= w_hold_nxt;
      r_fd    <= w_fd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_hold_nxt  = r_hold;
    w_fd_nxt    = r_fd;
    IMEM_ADDR   = r_pc;
    unique case (r_state)
      S_VEC: begin
        // Vector fetch ignores stall and flush: nothing downstream is live yet.
        IMEM_ADDR   = '0;
        w_pc_nxt    = IMEM_DATA[ADDR_W-1:0];
        w_fd_nxt    = FD_BUBBLE;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (FLUSH_BRANCH) begin
          w_pc_nxt = BRANCH_TARGET;
          w_fd_nxt = FD_BUBBLE;
        end else if (!w_stall) begin
          w_pc_nxt = w_pc_inc;
          if (IMEM_DATA[IMM_BIT]) begin
            w_hold_nxt  = IMEM_DATA;
            w_fd_nxt    = FD_BUBBLE;
            w_state_nxt = S_IMM;
          end else begin
            w_fd_nxt.instr = IMEM_DATA;
            w_fd_nxt.imm   = '0;
            w_fd_nxt.pc    = w_pc_inc;
            w_fd_nxt.valid = 1'b1;
          end
        end
      end
      S_IMM: begin
        // Second word is pure data; its IMM_BIT is deliberately not examined.
        if (FLUSH_BRANCH) begin
          w_pc_nxt    = BRANCH_TARGET;
          w_fd_nxt    = FD_BUBBLE;
          w_state_nxt = S_RUN;
        end else if (!w_stall) begin
          w_pc_nxt       = w_pc_inc;
          w_fd_nxt.instr = r_hold;
          w_fd_nxt.imm   = IMEM_DATA;
          w_fd_nxt.pc    = w_pc_inc;
          w_fd_nxt.valid = 1'b1;
          w_state_nxt    = S_RUN;
        end
      end
      default: begin
        IMEM_ADDR   = '0;
        w_fd_nxt    = FD_BUBBLE;
        w_state_nxt = S_VEC;
      end
    endcase
  end

  assign INSTR_F_D = r_fd.instr;
  assign IMM_F_D   = r_fd.imm;
  assign PC_F_D    = r_fd.pc;
  assign VALID_F_D = r_fd.valid;
  // Raw register fields; decode qualifies them with VALID_F_D.
  assign src_F_D   = r_fd.instr[SRC_LSB +: 3];
  assign dst_F_D   = r_fd.instr[DST_LSB +: 3];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed corner-case sequences, then a table-driven
// program run under random stalls with a scoreboard of expected F/D contents.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_ENB, F_D_ENB, FLUSH_BRANCH;
  logic [15:0] BRANCH_TARGET;
  logic [15:0] IMEM_ADDR, IMEM_DATA;
  logic [15:0] INSTR_F_D, IMM_F_D, PC_F_D;
  logic        VALID_F_D;
  logic [2:0]  src_F_D, dst_F_D;

  logic [15:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign IMEM_DATA = mem[IMEM_ADDR];

  fetch_unit #(.ADDR_W(16), .IMM_BIT(0), .SRC_LSB(5), .DST_LSB(8)) dut (
    .clk(clk), .rst(rst), .PC_ENB(PC_ENB), .F_D_ENB(F_D_ENB),
    .FLUSH_BRANCH(FLUSH_BRANCH), .BRANCH_TARGET(BRANCH_TARGET),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA),
    .INSTR_F_D(INSTR_F_D), .IMM_F_D(IMM_F_D), .PC_F_D(PC_F_D),
    .VALID_F_D(VALID_F_D), .src_F_D(src_F_D), .dst_F_D(dst_F_D)
  );

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] e_imm;
    logic [2:0]  e_src;
    logic [2:0]  e_dst;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [2:0]  src;
    logic [2:0]  dst;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    logic [15:0] a;
    logic adv;
    int cyc;

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h0040;
    mem[16'h0040] = 16'h1234;
    mem[16'h0041] = 16'h0220;
    mem[16'h0042] = 16'h0510;
    mem[16'h0050] = 16'h0A01;
    mem[16'h0051] = 16'hBEEF;
    mem[16'h0052] = 16'h0C03;
    mem[16'h0053] = 16'h1111;
    mem[16'h0200] = 16'h0300;
    mem[16'h0201] = 16'h0E05;
    mem[16'hFFFF] = 16'h0700;

    rst = 1'b1; PC_ENB = 1'b1; F_D_ENB = 1'b1; FLUSH_BRANCH = 1'b0; BRANCH_TARGET = '0;
    #2;
    chk("rst_instr", INSTR_F_D, 0);
    chk("rst_imm",   IMM_F_D, 0);
    chk("rst_pc",    PC_F_D, 0);
    chk("rst_valid", VALID_F_D, 0);
    chk("rst_addr",  IMEM_ADDR, 0);
    rst = 1'b0;

    // Reset vector
    tick;
    chk("vec_addr",  IMEM_ADDR, 16'h0040);
    chk("vec_valid", VALID_F_D, 0);
    tick;
    chk("first_instr", INSTR_F_D, 16'h1234);
    chk("first_pc",    PC_F_D, 16'h0041);
    chk("first_valid", VALID_F_D, 1);
    tick;
    chk("second_instr", INSTR_F_D, 16'h0220);
    chk("second_src",   src_F_D, 1);
    chk("second_dst",   dst_F_D, 2);

    // Load-use stall for two cycles at PC 0x42
    PC_ENB = 1'b0; F_D_ENB = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("stall_addr",  IMEM_ADDR, 16'h0042);
      chk("stall_instr", INSTR_F_D, 16'h0220);
      chk("stall_pc",    PC_F_D, 16'h0042);
    end
    PC_ENB = 1'b1; F_D_ENB = 1'b1;
    tick;
    chk("unstall_instr", INSTR_F_D, 16'h0510);
    chk("unstall_addr",  IMEM_ADDR, 16'h0043);

    // Branch takes priority over a simultaneous stall
    PC_ENB = 1'b0; FLUSH_BRANCH = 1'b1; BRANCH_TARGET = 16'h0100;
    tick;
    chk("brstall_addr",  IMEM_ADDR, 16'h0100);
    chk("brstall_valid", VALID_F_D, 0);
    chk("brstall_instr", INSTR_F_D, 0);
    PC_ENB = 1'b1; BRANCH_TARGET = 16'h0050;
    tick;
    FLUSH_BRANCH = 1'b0;

    // Two-word instruction with a one-cycle stall on the second word
    tick;
    chk("imm1_valid", VALID_F_D, 0);
    chk("imm1_addr",  IMEM_ADDR, 16'h0051);
    F_D_ENB = 1'b0;
    tick;
    chk("immst_addr",  IMEM_ADDR, 16'h0051);
    chk("immst_valid", VALID_F_D, 0);
    F_D_ENB = 1'b1;
    tick;
    chk("imm2_instr", INSTR_F_D, 16'h0A01);
    chk("imm2_imm",   IMM_F_D, 16'hBEEF);
    chk("imm2_pc",    PC_F_D, 16'h0052);
    chk("imm2_dst",   dst_F_D, 2);
    chk("imm2_src",   src_F_D, 0);
    chk("imm2_valid", VALID_F_D, 1);

    // Branch while waiting for the second word
    tick;
    chk("brimm_pre_addr", IMEM_ADDR, 16'h0053);
    FLUSH_BRANCH = 1'b1; BRANCH_TARGET = 16'h0200;
    tick;
    FLUSH_BRANCH = 1'b0;
    chk("brimm_addr",  IMEM_ADDR, 16'h0200);
    chk("brimm_valid", VALID_F_D, 0);
    chk("brimm_instr", INSTR_F_D, 0);
    tick;
    chk("brimm_next_instr", INSTR_F_D, 16'h0300);
    chk("brimm_next_imm",   IMM_F_D, 0);
    chk("brimm_next_pc",    PC_F_D, 16'h0201);

    // Asynchronous reset while in IMM, then PC wrap
    tick;
    mem[16'h0000] = 16'hFFFF;
    #2 rst = 1'b1;
    #1;
    chk("arst_instr", INSTR_F_D, 0);
    chk("arst_valid", VALID_F_D, 0);
    chk("arst_pc",    PC_F_D, 0);
    chk("arst_addr",  IMEM_ADDR, 0);
    rst = 1'b0;
    tick;
    chk("wrap_addr0", IMEM_ADDR, 16'hFFFF);
    tick;
    chk("wrap_instr", INSTR_F_D, 16'h0700);
    chk("wrap_pcfd",  PC_F_D, 16'h0000);
    chk("wrap_addr",  IMEM_ADDR, 16'h0000);
    chk("wrap_valid", VALID_F_D, 1);

    // Table-driven program under random stalls
    vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd0};
    vecs[1] = '{16'h07E0, 16'h0000, 16'h0000, 3'd7, 3'd7};
    vecs[2] = '{16'h0121, 16'hA5A5, 16'hA5A5, 3'd1, 3'd1};
    vecs[3] = '{16'h0A40, 16'h0000, 16'h0000, 3'd2, 3'd2};
    vecs[4] = '{16'h05A1, 16'h0001, 16'h0001, 3'd5, 3'd5};
    vecs[5] = '{16'hFFFE, 16'h0000, 16'h0000, 3'd7, 3'd7};
    vecs[6] = '{16'h0361, 16'hFFFF, 16'hFFFF, 3'd3, 3'd3};
    vecs[7] = '{16'h0481, 16'h1234, 16'h1234, 3'd4, 3'd4};
    vecs[8] = '{16'h0660, 16'h0000, 16'h0000, 3'd3, 3'd6};
    vecs[9] = '{16'h0101, 16'h0000, 16'h0000, 3'd0, 3'd1};

    a = 16'h0400;
    foreach (vecs[i]) begin
      mem[a] = vecs[i].w0;
      a++;
      if (vecs[i].w0[0]) begin
        mem[a] = vecs[i].w1;
        a++;
      end
      e.instr = vecs[i].w0;
      e.imm   = vecs[i].e_imm;
      e.pc    = a;
      e.src   = vecs[i].e_src;
      e.dst   = vecs[i].e_dst;
      sb.push_back(e);
    end

    rst = 1'b1;
    #1;
    mem[16'h0000] = 16'h0400;
    rst = 1'b0;
    adv = 1'b0;
    cyc = 0;
    while (sb.size() > 0 && cyc < 300) begin
      tick;
      cyc++;
      if (adv && VALID_F_D) begin
        e = sb.pop_front();
        chk("sb_instr", INSTR_F_D, e.instr);
        chk("sb_imm",   IMM_F_D, e.imm);
        chk("sb_pc",    PC_F_D, e.pc);
        chk("sb_src",   src_F_D, e.src);
        chk("sb_dst",   dst_F_D, e.dst);
      end
      PC_ENB  = ($urandom_range(0, 3) != 0);
      F_D_ENB = ($urandom_range(0, 3) != 0);
      adv = PC_ENB && F_D_ENB;
    end
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage and F/D pipeline register of the five-stage pipeline.
- Owns the PC, drives instruction memory, assembles one- and two-word instructions into the F/D register, and supplies src_F_D/dst_F_D to the decode-stage hazard detection unit.
- Obeys the hazard unit's PC_ENB/F_D_ENB stall outputs and the execute-stage branch flush.

Parameters:
- ADDR_W, 16: PC / instruction-memory address width.
- IMM_BIT, 0: instruction bit that marks a two-word (immediate) instruction.
- SRC_LSB, 5: LSB of the 3-bit source register field in the instruction word.
- DST_LSB, 8: LSB of the 3-bit destination register field in the instruction word.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- PC_ENB  in  1  from hazard unit; 0 = hold PC.
- F_D_ENB  in  1  from hazard unit; 0 = hold F/D register.
- FLUSH_BRANCH  in  1  taken branch resolved in execute.
- BRANCH_TARGET  in  ADDR_W  new PC when FLUSH_BRANCH=1.
- IMEM_ADDR  out  ADDR_W  instruction-memory address (combinational from state/PC).
- IMEM_DATA  in  16  instruction word; asynchronous read, valid in the same cycle.
- INSTR_F_D  out  16  registered instruction word.
- IMM_F_D  out  16  registered second word (immediate); 0 for one-word instructions.
- PC_F_D  out  ADDR_W  registered address following the last word of the instruction (return address).
- VALID_F_D  out  1  1 = F/D holds a real instruction; 0 = bubble.
- src_F_D  out  3  INSTR_F_D[SRC_LSB+2:SRC_LSB], combinational.
- dst_F_D  out  3  INSTR_F_D[DST_LSB+2:DST_LSB], combinational.

Behaviour:
- Reset (asynchronous, any state, including mid two-word fetch):
  - State goes to VEC; PC=0; hold register=0.
  - INSTR_F_D=0, IMM_F_D=0, PC_F_D=0, VALID_F_D=0.
- Stall: stall = !PC_ENB || !F_D_ENB. Either low freezes the PC, the state, the hold register and all F/D outputs.
- Flush priority: FLUSH_BRANCH > stall > normal advance.
- State VEC:
  - IMEM_ADDR=0.
  - Next edge: PC<=IMEM_DATA[ADDR_W-1:0], go to RUN, F/D stays bubble.
  - PC_ENB, F_D_ENB and FLUSH_BRANCH are ignored in VEC.
- State RUN (IMEM_ADDR=PC):
  - FLUSH_BRANCH: PC<=BRANCH_TARGET; F/D<=bubble (VALID 0, INSTR 0, IMM 0); stay in RUN.
  - Stall: hold everything.
  - Advance with IMEM_DATA[IMM_BIT]=0: INSTR_F_D<=IMEM_DATA, IMM_F_D<=0, PC_F_D<=PC+1, VALID<=1, PC<=PC+1.
  - Advance with IMEM_DATA[IMM_BIT]=1: hold register<=IMEM_DATA, PC<=PC+1, F/D<=bubble, go to IMM.
- State IMM (IMEM_ADDR=PC):
  - FLUSH_BRANCH: discard the hold register, PC<=BRANCH_TARGET, F/D<=bubble, go to RUN.
  - Stall: hold everything, stay in IMM.
  - Advance: INSTR_F_D<=hold register, IMM_F_D<=IMEM_DATA, PC_F_D<=PC+1, VALID<=1, PC<=PC+1, go to RUN.
  - The second word is never decoded for IMM_BIT.
- Arithmetic:
  - PC+1 is modulo 2^ADDR_W; PC=2^ADDR_W-1 wraps to 0 with no flag.
  - Reset vector uses the low ADDR_W bits of IMEM_DATA.
- Latency: a one-word instruction reaches F/D one edge after its address is presented; a two-word instruction takes two edges plus any stall cycles, with a one-cycle bubble before it.
- Bubble fields: src_F_D/dst_F_D are raw fields (0 for a bubble). Consumers qualify them with VALID_F_D; this block does not gate them.

Test Plan:
- Reset vector: IMEM[0]=0x0040, release rst -> IMEM_ADDR=0, next cycle PC=0x40, IMEM_ADDR=0x40, VALID_F_D=0; one edge later INSTR_F_D=IMEM[0x40], PC_F_D=0x41, VALID_F_D=1.
- Load-use stall: in RUN at PC=0x42, hold PC_ENB=F_D_ENB=0 for 2 cycles -> IMEM_ADDR stays 0x42 and INSTR_F_D/PC_F_D unchanged; after release, advances to PC=0x43 on the next edge.
- Branch beats stall: PC_ENB=0 together with FLUSH_BRANCH=1, BRANCH_TARGET=0x100 -> next cycle PC=0x100, VALID_F_D=0.
- Two-word with stall: IMEM[0x50]=0x0A01, IMEM[0x51]=0xBEEF:
  - Edge 1: state IMM, bubble in F/D.
  - 1-cycle stall: IMEM_ADDR holds 0x51.
  - Next edge: INSTR_F_D=0x0A01, IMM_F_D=0xBEEF, PC_F_D=0x52, dst_F_D=2, src_F_D=0.
- Branch in IMM: FLUSH_BRANCH=1, target 0x200, while in IMM -> RUN, PC=0x200, first word dropped, VALID_F_D=0.
- Async reset mid-IMM plus wrap: assert rst between edges -> outputs clear immediately, state VEC. Separately, PC=0xFFFF one-word instruction -> PC_F_D=0x0000, PC=0x0000.
